// File: rtl/dma_line_writer.sv
// dma_line_writer: bus-mastering DMA that copies device lines into memory, one 4-word burst at a time.
module dma_line_writer #(
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_ready,
  output logic              bus_req,
  input  logic              bus_grant,
  input  logic              dev_valid,
  input  logic [63:0]       dev_data,
  output logic              dev_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  output logic              dma_end,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, REQ, FETCH, WRITE, DONE} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_left;
  logic              w_full;
  logic [LEN_W-1:0]  w_left_next;
  logic [3:0]        w_mask;
  assign w_full      = r_left >= LEN_W'(LINE_WORDS);
  assign w_left_next = w_full ? r_left - LEN_W'(LINE_WORDS) : '0;
  assign w_mask      = w_full ? 4'b1111 : (4'b1 << r_left[1:0]) - 4'd1;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_left    <= '0;
      cmd_ready <= 1'b1;
      bus_req   <= 1'b0;
      dev_ready <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      dma_end   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dev_ready <= 1'b0;
      dma_end   <= 1'b0;
      case (r_state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          if (cmd_len == '0) begin
            r_state <= DONE;
            dma_end <= 1'b1;
          end else begin
            r_state <= REQ;
            bus_req <= 1'b1;
            r_addr  <= cmd_addr & ~ADDR_W'(3);
            r_left  <= cmd_len;
          end
        end
        REQ: if (bus_grant) r_state <= FETCH;
        // Losing grant here backs off before any line is consumed.
        FETCH: if (!bus_grant) r_state <= REQ;
        else if (dev_valid) begin
          r_state   <= WRITE;
          dev_ready <= 1'b1;
          mem_write <= 1'b1;
          mem_addr  <= r_addr;
          mem_wdata <= dev_data;
          mem_wmask <= w_mask;
        end
        WRITE: if (mem_ack) begin
          mem_write <= 1'b0;
          r_addr    <= r_addr + ADDR_W'(LINE_WORDS);
          r_left    <= w_left_next;
          if (w_left_next == '0) begin
            r_state <= DONE;
            bus_req <= 1'b0;
            dma_end <= 1'b1;
          end else r_state <= bus_grant ? FETCH : REQ;
        end
        DONE: begin
          r_state   <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_line_writer.sv
// tb_dma_line_writer: randomized scoreboard bench; expected bursts come from a per-command line model.
module tb_dma_line_writer;
  logic        clk = 0, reset_n = 0, cmd_valid = 0, bus_grant = 1, mem_ack = 0, dev_valid = 0;
  logic [15:0] cmd_addr = 0, cmd_len = 0;
  logic [63:0] dev_data = 0;
  logic        cmd_ready, bus_req, dev_ready, mem_write, dma_end, busy;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [3:0]  mem_wmask;
  typedef struct packed {logic [15:0] a; logic [3:0] m; logic [63:0] d;} burst_t;
  burst_t      exp_q[$];
  logic [63:0] dev_q[$];
  int checks = 0, errors = 0, n_end = 0, n_dr = 0, lat = 4;
  bit dev_rnd = 0, saw_req = 0, saw_wr = 0;
  dma_line_writer dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .bus_req(bus_req), .bus_grant(bus_grant), .dev_valid(dev_valid),
    .dev_data(dev_data), .dev_ready(dev_ready), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack), .dma_end(dma_end), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask
  // Memory: ack `lat` cycles after a write request is first seen.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 0;
      if (mem_write) begin
        cnt++;
        if (cnt >= lat) begin mem_ack = 1; cnt = 0; end
      end else cnt = 0;
    end
  end
  // Device: presents queued lines in order, drops one per dev_ready pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (dev_ready && dev_q.size() > 0) void'(dev_q.pop_front());
      dev_valid = dev_q.size() > 0 && (!dev_rnd || $urandom_range(0, 2) != 0);
      dev_data  = dev_q.size() > 0 ? dev_q[0] : 64'h0;
    end
  end
  // Monitor: compares each new burst against the scoreboard and checks it stays stable.
  initial begin
    burst_t cur, e;
    bit pw = 0, pe = 0, pd = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (bus_req) saw_req = 1;
      if (mem_write) saw_wr = 1;
      if (dev_ready) begin n_dr++; chk("dev_ready_width", pd, 0); end
      if (dma_end) begin
        n_end++;
        chk("dma_end_width", pe, 0);
        chk("dma_end_cmd_ready", cmd_ready, 0);
      end
      if (mem_write && !pw) begin
        cur = '{mem_addr, mem_wmask, mem_wdata};
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_burst got addr=%h want none", mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("burst_addr", mem_addr, e.a);
          chk("burst_mask", mem_wmask, e.m);
          chk("burst_data", mem_wdata, e.d);
        end
      end else if (mem_write) chk("burst_hold", {mem_addr, mem_wmask, mem_wdata}, cur);
      pw = mem_write; pe = dma_end; pd = dev_ready;
    end
  end
  task automatic issue(input logic [15:0] a, input logic [15:0] len);
    int t = 0, left = int'(len);
    logic [15:0] ad = a & 16'hFFFC;
    while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    while (left > 0) begin
      int w = left > 4 ? 4 : left;
      logic [63:0] d = {$urandom, $urandom};
      dev_q.push_back(d);
      exp_q.push_back('{ad, 4'((1 << w) - 1), d});
      ad += 16'd4;
      left -= w;
    end
    cmd_valid = 1; cmd_addr = a; cmd_len = len;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = 16'($urandom); cmd_len = 16'($urandom);
  endtask
  task automatic wait_end(input int e0, input string name, output int t);
    t = 0;
    while (n_end == e0 && t < 3000) begin @(negedge clk); t++; end
    chk(name, n_end - e0, 1);
  endtask
  task automatic wait_write(input bit lvl, input string name);
    int t = 0;
    while (mem_write !== lvl && t < 500) begin @(negedge clk); t++; end
    chk(name, mem_write, lvl);
  endtask
  task automatic check_reset_outs(input string name);
    chk({name, "_ready"}, cmd_ready, 1);
    chk({name, "_ctl"}, {bus_req, dev_ready, mem_write, dma_end, busy, mem_wmask}, 0);
    chk({name, "_data"}, {mem_addr, mem_wdata}, 0);
  endtask
  initial begin
    int e0, d0, t;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    reset_n = 1;
    @(negedge clk);
    e0 = n_end; d0 = n_dr;
    issue(16'h0017, 12);
    wait_end(e0, "t1_end", t);
    repeat (3) @(negedge clk);
    chk("t1_dev_ready", n_dr - d0, 3);
    chk("t1_cmd_ready", cmd_ready, 1);
    chk("t1_drain", exp_q.size(), 0);
    e0 = n_end; d0 = n_dr;
    issue(16'h0040, 6);
    wait_end(e0, "t2_end", t);
    repeat (2) @(negedge clk);
    chk("t2_dev_ready", n_dr - d0, 2);
    chk("t2_drain", exp_q.size(), 0);
    e0 = n_end; saw_req = 0; saw_wr = 0;
    issue(16'h0123, 0);
    wait_end(e0, "t3_end", t);
    chk("t3_latency_ok", t <= 2, 1);
    repeat (2) @(negedge clk);
    chk("t3_no_req_write", {saw_req, saw_wr}, 0);
    bus_grant = 0; e0 = n_end; d0 = n_dr;
    issue(16'h0A08, 8);
    repeat (10) @(negedge clk);
    chk("t4_wait_grant", {bus_req, mem_write, busy}, 3'b101);
    chk("t4_no_fetch0", n_dr - d0, 0);
    bus_grant = 1;
    wait_write(1, "t4_first_write");
    bus_grant = 0;
    wait_write(0, "t4_first_ack");
    repeat (8) @(negedge clk);
    chk("t4_hold_req", {bus_req, mem_write}, 2'b10);
    chk("t4_no_fetch1", n_dr - d0, 1);
    bus_grant = 1;
    wait_end(e0, "t4_end", t);
    repeat (2) @(negedge clk);
    chk("t4_drain", exp_q.size(), 0);
    e0 = n_end;
    issue(16'h0200, 8);
    wait_write(1, "t5_write");
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    check_reset_outs("t5_reset");
    reset_n = 1;
    exp_q.delete(); dev_q.delete(); saw_wr = 0;
    repeat (8) @(negedge clk);
    chk("t5_no_end", n_end - e0, 0);
    chk("t5_no_write", saw_wr, 0);
    e0 = n_end;
    issue(16'h0300, 4);
    wait_end(e0, "t5_new_end", t);
    repeat (2) @(negedge clk);
    chk("t5_drain", exp_q.size(), 0);
    e0 = n_end;
    issue(16'hFFFC, 8);
    wait_write(1, "t6_write");
    cmd_valid = 1; cmd_addr = 16'h0500; cmd_len = 16'd4;
    @(negedge clk);
    cmd_valid = 0;
    wait_end(e0, "t6_end", t);
    repeat (10) @(negedge clk);
    chk("t6_one_end", n_end - e0, 1);
    chk("t6_drain", exp_q.size(), 0);
    chk("t6_idle", {cmd_ready, busy}, 2'b10);
    dev_rnd = 1;
    for (int i = 0; i < 12; i++) begin
      lat = $urandom_range(1, 5);
      e0 = n_end;
      issue(16'($urandom), 16'($urandom_range(0, 20)));
      wait_end(e0, "rnd_end", t);
      repeat (2) @(negedge clk);
      chk("rnd_drain", exp_q.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
